// File: rtl/fp_mult_seq.sv
// Multi-cycle IEEE-754-style multiplier: radix-2 shift-add mantissa product, RNE rounding, zero/inf/NaN fast path.
// Latency: MAN_W+3 edges (accept edge included) on the normal path, 2 edges on the special fast path; one op in flight.
// Backpressure: result and flags held in DONE until out_ready; in_ready is high only in IDLE.
module fp_mult_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflag,
  output logic                   underflag,
  output logic                   invalid
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(MAN_W + 2);
  localparam logic [EW-1:0]        BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]         QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t                 state_q, state_d;
  logic [MAN_W:0]         ma_q, mb_q;
  logic [PW-1:0]          acc_q;
  logic [CW-1:0]          cnt_q;
  logic signed [EW-1:0]   exp_q;
  logic                   sign_q;
  logic                   spec_q;
  logic                   spec_inv_q;
  logic [W-1:0]           spec_res_q;

  // operand classification (exp all-ones = inf/NaN, exp zero = zero or flushed subnormal)
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic a_max, a_min, b_max, b_min, a_nan, b_nan, a_inf, b_inf;
  logic in_sign, any_special, accept;

  assign a_exp       = a[W-2:MAN_W];
  assign b_exp       = b[W-2:MAN_W];
  assign a_frac      = a[MAN_W-1:0];
  assign b_frac      = b[MAN_W-1:0];
  assign a_max       = &a_exp;
  assign b_max       = &b_exp;
  assign a_min       = ~|a_exp;
  assign b_min       = ~|b_exp;
  assign a_nan       = a_max & (|a_frac);
  assign b_nan       = b_max & (|b_frac);
  assign a_inf       = a_max & ~(|a_frac);
  assign b_inf       = b_max & ~(|b_frac);
  assign in_sign     = a[W-1] ^ b[W-1];
  assign any_special = a_max | a_min | b_max | b_min;
  assign accept      = in_valid & in_ready;

  // special-value result selected at accept time
  logic [W-1:0] spec_res;
  logic         spec_inv;
  always_comb begin
    spec_res = {in_sign, {(W-1){1'b0}}};
    spec_inv = 1'b0;
    if (a_nan | b_nan | (a_inf & b_min) | (a_min & b_inf)) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (a_inf | b_inf) begin
      spec_res = {in_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // normalise, round to nearest even and range-check the finished product
  logic                 msb, grd, stk, rnd, ovf, unf;
  logic [MAN_W-1:0]     frac_n;
  logic [MAN_W:0]       frac_sum;
  logic signed [EW-1:0] exp_r;
  logic [W-1:0]         norm_res;
  always_comb begin
    msb = acc_q[PW-1];
    if (msb) begin
      frac_n = acc_q[2*MAN_W:MAN_W+1];
      grd    = acc_q[MAN_W];
      stk    = |acc_q[MAN_W-1:0];
    end else begin
      frac_n = acc_q[2*MAN_W-1:MAN_W];
      grd    = acc_q[MAN_W-1];
      stk    = |acc_q[MAN_W-2:0];
    end
    rnd      = grd & (stk | frac_n[0]);
    frac_sum = {1'b0, frac_n} + {{MAN_W{1'b0}}, rnd};
    // a carry out leaves frac_sum[MAN_W-1:0] all zero, so only the exponent needs bumping
    exp_r    = exp_q + EW'(msb) + EW'(frac_sum[MAN_W]);
    ovf      = (exp_r >= EMAX);
    unf      = exp_r[EW-1] | (exp_r == '0);
    norm_res = {sign_q, exp_r[EXP_W-1:0], frac_sum[MAN_W-1:0]};
    if (ovf)      norm_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (unf) norm_res = {sign_q, {(W-1){1'b0}}};
  end

  // one multiplier bit per cycle, LSB first
  logic [PW-1:0] addend;
  assign addend = mb_q[0] ? (PW'(ma_q) << cnt_q) : '0;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = any_special ? NORM : MUL;
      MUL:  if (cnt_q == CW'(MAN_W)) state_d = NORM;
      NORM: state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // datapath: operand capture, accumulation, result and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_q       <= '0;
      mb_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_inv_q <= 1'b0;
      spec_res_q <= '0;
      result     <= '0;
      overflag   <= 1'b0;
      underflag  <= 1'b0;
      invalid    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          ma_q       <= {1'b1, a_frac};
          mb_q       <= {1'b1, b_frac};
          acc_q      <= '0;
          cnt_q      <= '0;
          exp_q      <= EW'(a_exp) + EW'(b_exp) - BIAS;
          sign_q     <= in_sign;
          spec_q     <= any_special;
          spec_inv_q <= spec_inv;
          spec_res_q <= spec_res;
        end
        MUL: begin
          acc_q <= acc_q + addend;
          mb_q  <= mb_q >> 1;
          cnt_q <= cnt_q + 1'b1;
        end
        NORM: begin
          result    <= spec_q ? spec_res_q : norm_res;
          invalid   <= spec_q & spec_inv_q;
          overflag  <= ~spec_q & ovf;
          underflag <= ~spec_q & unf;
        end
        DONE: if (out_ready) begin
          overflag  <= 1'b0;
          underflag <= 1'b0;
          invalid   <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mult_seq.sv
// Bench for fp_mult_seq: directed and random operands, scoreboard checked by an independent monitor.
// Reference: integer product with remainder-vs-half rounding; latency measured from the accept edge.
// Covers backpressure hold, ignored in_valid while busy, and asynchronous reset mid-multiply.
module tb_fp_mult_seq;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, overflag, underflag, invalid;
  logic [W-1:0] result;

  fp_mult_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflag(overflag), .underflag(underflag), .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;   // {over, under, invalid}
    int          lat;
    int          acc_cyc;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  rdy_mode = 0;      // 0: ready high, 1: ready low, 2: random
  int  hs_count = 0;
  int  issued = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // reference multiply from the rules: exact integer product, then RNE by remainder
  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [2:0] fl,
                                  output logic sp);
    int ex, ey, e, sh;
    logic s, nx, ny, ix, iy, zx, zy;
    longint unsigned mx, my, p, m, rem, half;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    zx = (ex == 0);
    zy = (ey == 0);
    sp = (ex == 255) || (ex == 0) || (ey == 255) || (ey == 0);
    fl = 3'b000;
    r  = '0;
    if (nx || ny || (ix && zy) || (zx && iy)) begin
      r = 32'h7FC00000; fl = 3'b001;
    end else if (ix || iy) begin
      r = {s, 8'hFF, 23'h0};
    end else if (zx || zy) begin
      r = {s, 31'h0};
    end else begin
      mx = 64'h800000 + longint'(x[22:0]);
      my = 64'h800000 + longint'(y[22:0]);
      p  = mx * my;
      e  = ex + ey - 127;
      sh = (p >= (64'd1 << 47)) ? 24 : 23;
      e  = e + sh - 23;
      m  = p >> sh;
      rem  = p - (m << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 1;
      if (m == (64'd1 << 24)) begin m = m >> 1; e = e + 1; end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0}; fl = 3'b100;
      end else if (e <= 0) begin
        r = {s, 31'h0}; fl = 3'b010;
      end else begin
        r = {s, e[7:0], m[22:0]};
      end
    end
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    sb_t  e;
    logic sp;
    int   n;
    ref_mul(x, y, e.res, e.flags, sp);
    e.lat = sp ? 2 : MAN_W + 3;
    @(posedge clk); #1;
    a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 500) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", {63'b0, in_ready}, 64'd1);
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    issued++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 15);
    if (k == 0)      r[30:23] = 8'h00;
    else if (k == 1) begin
      r[30:23] = 8'hFF;
      if ($urandom_range(0, 1) == 0) r[22:0] = '0;
    end else if (k >= 6) r[30:23] = 8'($urandom_range(110, 145));
    return r;
  endfunction

  // out_ready driver
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0)      out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = 1'b0;
      else                    out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // monitor: latency on out_valid rise, result/flags on handshake
  initial begin : monitor
    logic prev;
    sb_t  e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (out_valid && !prev) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_output actual=result %0h with no pending op", result);
          end else begin
            chk("latency", 64'(cyc - sb[0].acc_cyc + 1), 64'(sb[0].lat));
          end
        end
        if (out_valid && out_ready && sb.size() != 0) begin
          e = sb.pop_front();
          chk("result", 64'(result), 64'(e.res));
          chk("flags", 64'({overflag, underflag, invalid}), 64'(e.flags));
          hs_count++;
        end
        prev = out_valid;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] dir_a [8] = '{32'h40400000, 32'h3F800001, 32'h3F800001, 32'h7F000000,
                             32'h00800000, 32'h7F800000, 32'hFF800000, 32'h7FC00001};
  logic [31:0] dir_b [8] = '{32'h40200000, 32'h3FC00000, 32'h3F800001, 32'h40000000,
                             32'h3F000000, 32'h80000000, 32'h40000000, 32'h3F800000};
  logic [31:0] dir_r [8] = '{32'h40F00000, 32'h3FC00002, 32'h3F800002, 32'h7F800000,
                             32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000};

  initial begin : main
    logic [31:0] er;
    logic [2:0]  ef;
    logic        esp;
    int          n;

    // reset state
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", 64'({overflag, underflag, invalid}), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // the reference model must reproduce the hand-derived plan values
    for (int i = 0; i < 8; i++) begin
      ref_mul(dir_a[i], dir_b[i], er, ef, esp);
      chk($sformatf("model_vec%0d", i), 64'(er), 64'(dir_r[i]));
    end

    // directed vectors through the DUT
    for (int i = 0; i < 8; i++) begin
      issue(dir_a[i], dir_b[i]);
      drain();
      @(negedge clk);
      chk("in_ready_after_hs", 64'(in_ready), 64'd1);
    end

    // backpressure: hold out_ready low, poke in_valid, expect a frozen result
    @(negedge clk); rdy_mode = 1;
    @(posedge clk);
    issue(32'h40400000, 32'h40200000);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_out_valid_seen", 64'(out_valid), 64'd1);
    a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_result", 64'(result), 64'h40F00000);
      chk("bp_flags", 64'({overflag, underflag, invalid}), 64'd0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    drain();
    repeat (40) @(negedge clk);
    chk("bp_single_handshake", 64'(hs_count), 64'(issued));

    // reset while multiplying
    issue(32'h40400000, 32'h40200000);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    issued--;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_flags", 64'({overflag, underflag, invalid}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(32'h40400000, 32'h40200000);
    drain();

    // random operands with random backpressure
    @(negedge clk); rdy_mode = 2;
    for (int i = 0; i < 150; i++) issue(rnd_op(), rnd_op());
    drain();
    @(negedge clk); rdy_mode = 0;
    repeat (40) @(negedge clk);
    chk("total_handshakes", 64'(hs_count), 64'(issued));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
